// File: rtl/speles_taimeris.sv
// rtl/speles_taimeris.sv - game countdown timer: 1 Hz prescaler, edge-triggered load, BCD and warning outputs
module speles_taimeris #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int WARN_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       time_f,
  input  logic [4:0] time_v,
  input  logic       stop,
  output logic       end_f,
  output logic [4:0] remaining,
  output logic [1:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       running,
  output logic       warn
);
  localparam int            PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [4:0]    WARN_V    = 5'(WARN_SEC);

  typedef enum logic [1:0] {IDLE, RUN, HALTED, EXPIRED} state_t;

  state_t        state_q, state_d;
  logic          time_f_d_q, time_f_d_d;
  logic          armed_q, armed_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    rem_q, rem_d;
  logic          end_f_q, end_f_d;
  logic          running_q, running_d;
  logic          warn_q, warn_d;
  logic [1:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          load;
  logic          tick;

  always_comb begin
    // armed_q masks the first post-reset cycle so a time_f held through rst is not seen as an edge
    load       = time_f & ~time_f_d_q & armed_q;
    tick       = (presc_q == PRESC_MAX);
    state_d    = state_q;
    presc_d    = presc_q;
    rem_d      = rem_q;
    end_f_d    = end_f_q;
    armed_d    = 1'b1;
    time_f_d_d = time_f;

    if (load) begin
      rem_d   = time_v;
      presc_d = '0;
      if (time_v != 5'd0) begin
        state_d = RUN;
        end_f_d = 1'b0;
      end else begin
        state_d = EXPIRED;
        end_f_d = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (stop) begin
            state_d = HALTED;
          end else if (tick) begin
            presc_d = '0;
            rem_d   = rem_q - 5'd1;
            if (rem_q == 5'd1) begin
              state_d = EXPIRED;
              end_f_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: ;
      endcase
    end

    running_d = (state_d == RUN);
    warn_d    = (rem_d != 5'd0) && (rem_d <= WARN_V);

    if (rem_d >= 5'd30) begin
      tens_d = 2'd3;
      ones_d = 4'(rem_d - 5'd30);
    end else if (rem_d >= 5'd20) begin
      tens_d = 2'd2;
      ones_d = 4'(rem_d - 5'd20);
    end else if (rem_d >= 5'd10) begin
      tens_d = 2'd1;
      ones_d = 4'(rem_d - 5'd10);
    end else begin
      tens_d = 2'd0;
      ones_d = rem_d[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      time_f_d_q <= 1'b0;
      armed_q    <= 1'b0;
      presc_q    <= '0;
      rem_q      <= 5'd0;
      end_f_q    <= 1'b0;
      running_q  <= 1'b0;
      warn_q     <= 1'b0;
      tens_q     <= 2'd0;
      ones_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      time_f_d_q <= time_f_d_d;
      armed_q    <= armed_d;
      presc_q    <= presc_d;
      rem_q      <= rem_d;
      end_f_q    <= end_f_d;
      running_q  <= running_d;
      warn_q     <= warn_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
    end
  end

  assign end_f     = end_f_q;
  assign remaining = rem_q;
  assign bcd_tens  = tens_q;
  assign bcd_ones  = ones_q;
  assign running   = running_q;
  assign warn      = warn_q;

endmodule

// File: tb/tb_speles_taimeris.sv
// tb/tb_speles_taimeris.sv - directed and randomized bench for speles_taimeris against a time-arithmetic model
module tb_speles_taimeris;
  localparam int HZ = 4;
  localparam int WS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       time_f;
  logic [4:0] time_v;
  logic       stop;
  logic       end_f;
  logic [4:0] remaining;
  logic [1:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       running;
  logic       warn;

  speles_taimeris #(.CLK_HZ(HZ), .WARN_SEC(WS)) dut (
    .clk       (clk),
    .rst       (rst),
    .time_f    (time_f),
    .time_v    (time_v),
    .stop      (stop),
    .end_f     (end_f),
    .remaining (remaining),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .running   (running),
    .warn      (warn)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: remaining is the loaded seconds minus whole seconds elapsed since the load edge.
  // mode 0 idle, 1 counting, 2 halted, 3 expired.
  int cyc = 0;
  int m_mode = 0;
  int m_tv = 0;
  int m_load_cyc = 0;
  int m_frozen = 0;
  bit m_prev = 1'b1;

  function automatic int model_rem();
    case (m_mode)
      1:       return m_tv - (cyc - m_load_cyc) / HZ;
      2:       return m_frozen;
      default: return 0;
    endcase
  endfunction

  task automatic step();
    int r;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_mode = 0;
      m_prev = 1'b1;
    end else begin
      if (time_f && !m_prev) begin
        m_tv       = time_v;
        m_load_cyc = cyc;
        m_mode     = (time_v == 0) ? 3 : 1;
      end else if (m_mode == 1) begin
        if (stop) begin
          m_frozen = m_tv - (cyc - 1 - m_load_cyc) / HZ;
          m_mode   = 2;
        end else if (m_tv - (cyc - m_load_cyc) / HZ <= 0) begin
          m_mode = 3;
        end
      end
      m_prev = time_f;
    end
    #1;
    r = model_rem();
    check_eq("remaining", 32'(remaining), r);
    check_eq("end_f",     32'(end_f),     (m_mode == 3) ? 1 : 0);
    check_eq("running",   32'(running),   (m_mode == 1) ? 1 : 0);
    check_eq("warn",      32'(warn),      (r > 0 && r <= WS) ? 1 : 0);
    check_eq("bcd_tens",  32'(bcd_tens),  r / 10);
    check_eq("bcd_ones",  32'(bcd_ones),  r % 10);
  endtask

  initial begin
    rst    = 1'b1;
    time_f = 1'b0;
    time_v = 5'd0;
    stop   = 1'b0;
    step();
    step();
    check_eq("reset_remaining", 32'(remaining), 0);
    check_eq("reset_end_f",     32'(end_f),     0);
    check_eq("reset_running",   32'(running),   0);
    rst = 1'b0;
    step();

    // normal countdown of 3 s, then time_f left high through expiry
    time_v = 5'd3;
    time_f = 1'b1;
    step();
    check_eq("load3_remaining", 32'(remaining), 3);
    check_eq("load3_running",   32'(running),   1);
    for (int i = 0; i < 11; i++) step();
    check_eq("pre_expiry_end_f", 32'(end_f), 0);
    step();
    check_eq("expiry_end_f",   32'(end_f),   1);
    check_eq("expiry_running", 32'(running), 0);
    for (int i = 0; i < 8; i++) step();
    check_eq("held_tf_end_f", 32'(end_f), 1);
    time_f = 1'b0;
    step();
    time_v = 5'd17;
    time_f = 1'b1;
    step();
    check_eq("load17_end_f",     32'(end_f),     0);
    check_eq("load17_remaining", 32'(remaining), 17);
    check_eq("load17_tens",      32'(bcd_tens),  1);
    check_eq("load17_ones",      32'(bcd_ones),  7);

    // stop coinciding with the final tick
    time_f = 1'b0;
    step();
    time_v = 5'd1;
    time_f = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("halt_remaining", 32'(remaining), 1);
    check_eq("halt_running",   32'(running),   0);
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("halt_end_f", 32'(end_f), 0);
    end

    // restart while running
    time_f = 1'b0;
    step();
    time_v = 5'd8;
    time_f = 1'b1;
    step();
    time_f = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check_eq("pre_restart_remaining", 32'(remaining), 5);
    time_v = 5'd30;
    time_f = 1'b1;
    step();
    check_eq("restart_remaining", 32'(remaining), 30);
    check_eq("restart_tens",      32'(bcd_tens),  3);
    check_eq("restart_ones",      32'(bcd_ones),  0);
    for (int i = 0; i < 3; i++) step();
    check_eq("restart_hold", 32'(remaining), 30);
    step();
    check_eq("restart_first_dec", 32'(remaining), 29);

    // zero load
    time_f = 1'b0;
    step();
    time_v = 5'd0;
    time_f = 1'b1;
    step();
    check_eq("zero_end_f",   32'(end_f),   1);
    check_eq("zero_running", 32'(running), 0);

    // reset mid-count with time_f held high
    time_f = 1'b0;
    step();
    time_v = 5'd9;
    time_f = 1'b1;
    step();
    check_eq("load9_remaining", 32'(remaining), 9);
    rst = 1'b1;
    step();
    check_eq("midrst_remaining", 32'(remaining), 0);
    check_eq("midrst_end_f",     32'(end_f),     0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_eq("post_rst_no_load", 32'(remaining), 0);
    time_f = 1'b0;
    step();
    time_v = 5'd4;
    time_f = 1'b1;
    step();
    check_eq("post_rst_reload", 32'(remaining), 4);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) == 0) time_f = ~time_f;
      time_v = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      stop = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
